// File: rtl/uart_io_buffer_if.sv
// uart_io_buffer_if: core-side word handshakes of uart_io_buffer (TX words out, RX words in).
// The core drives through the master modport; the buffer sits on the slave side.
interface uart_io_buffer_if #(
    parameter int unsigned WORD_BYTES = 1
);
    localparam int unsigned W = 8 * WORD_BYTES;

    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;

    modport master (
        output out_valid, out_data, in_ready,
        input  out_ready, in_valid, in_data
    );

    modport slave (
        input  out_valid, out_data, in_ready,
        output out_ready, in_valid, in_data
    );
endinterface

// File: rtl/uart_io_buffer.sv
// uart_io_buffer: TX/RX word FIFOs with an LSB-first TX byte serializer and RX word assembler.
// Optional UART_IO_FERR_DROP_EN: drop framing-errored bytes and resynchronise word alignment.
module uart_io_buffer #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned WORD_BYTES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_io_buffer_if.slave       core,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    input  logic                  tx_busy,
    input  logic [7:0]            rx_data,
    input  logic                  rx_ready,
    input  logic                  rx_ferr,
    output logic [DEPTH_LOG2:0]   tx_level,
    output logic [DEPTH_LOG2:0]   rx_level,
    output logic                  rx_overflow,
    input  logic                  ovf_clr
);
    localparam int unsigned W     = 8 * WORD_BYTES;
    localparam int unsigned AW    = DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = 2;

    typedef enum logic [1:0] {IDLE, START, GUARD, WAIT} tx_state_t;

    // TX FIFO; out_ready depends only on the registered pointers
    logic [W-1:0]  tx_mem [DEPTH];
    logic [PW-1:0] tx_wr, tx_rd, tx_wr_n, tx_rd_n;
    logic          tx_full, tx_empty, tx_push, tx_pop;

    assign tx_full        = (tx_wr[AW] != tx_rd[AW]) && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);
    assign tx_empty       = (tx_wr == tx_rd);
    assign core.out_ready = ~tx_full;
    assign tx_push        = core.out_valid & ~tx_full;
    assign tx_wr_n        = tx_wr + PW'(tx_push);
    assign tx_rd_n        = tx_rd + PW'(tx_pop);

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr[AW-1:0]] <= core.out_data;
    end

    tx_state_t     state_q, state_d;
    logic [W-1:0]  shift_q, shift_d;
    logic [CW-1:0] bcnt_q, bcnt_d;

    // GUARD spends one cycle blind to tx_busy while uart_tx raises it
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcnt_d  = bcnt_q;
        tx_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!tx_empty) begin
                    tx_pop  = 1'b1;
                    shift_d = tx_mem[tx_rd[AW-1:0]];
                    bcnt_d  = '0;
                    state_d = START;
                end
            end
            START: state_d = GUARD;
            GUARD: state_d = WAIT;
            WAIT: begin
                if (!tx_busy) begin
                    if (bcnt_q == CW'(WORD_BYTES - 1)) begin
                        state_d = IDLE;
                    end else begin
                        shift_d = shift_q >> 8;
                        bcnt_d  = bcnt_q + CW'(1);
                        state_d = START;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bcnt_q   <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            tx_wr    <= '0;
            tx_rd    <= '0;
            tx_level <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bcnt_q   <= bcnt_d;
            tx_start <= (state_d == START);
            if (state_d == START) tx_data <= shift_d[7:0];
            tx_wr    <= tx_wr_n;
            tx_rd    <= tx_rd_n;
            tx_level <= tx_wr_n - tx_rd_n;
        end
    end

    // RX assembler and FIFO
    logic [W-1:0]  rx_mem [DEPTH];
    logic [PW-1:0] rx_wr, rx_rd, rx_wr_n, rx_rd_n;
    logic [W-1:0]  rx_asm, rx_word;
    logic [CW-1:0] rx_cnt;
    logic          rx_full, rx_empty, rx_pop, rx_push, rx_drop, rx_accept, rx_done, ovf_set;

`ifdef UART_IO_FERR_DROP_EN
    assign rx_drop = rx_ready & rx_ferr;
`else
    logic unused_ferr;
    assign unused_ferr = rx_ferr;
    assign rx_drop     = 1'b0;
`endif

    assign rx_full       = (rx_wr[AW] != rx_rd[AW]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);
    assign rx_empty      = (rx_wr == rx_rd);
    assign core.in_valid = ~rx_empty;
    assign core.in_data  = rx_empty ? '0 : rx_mem[rx_rd[AW-1:0]];
    assign rx_pop        = core.in_ready & ~rx_empty;
    assign rx_accept     = rx_ready & ~rx_drop;
    assign rx_done       = rx_accept && (rx_cnt == CW'(WORD_BYTES - 1));
    // a full FIFO still takes the word when the head leaves in the same cycle
    assign rx_push       = rx_done & (~rx_full | rx_pop);
    assign ovf_set       = rx_done & rx_full & ~rx_pop;
    assign rx_wr_n       = rx_wr + PW'(rx_push);
    assign rx_rd_n       = rx_rd + PW'(rx_pop);

    always_comb begin
        rx_word = rx_asm;
        for (int i = 0; i < int'(WORD_BYTES); i++) begin
            if (rx_cnt == CW'(i)) rx_word[i*8 +: 8] = rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr[AW-1:0]] <= rx_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_asm      <= '0;
            rx_cnt      <= '0;
            rx_wr       <= '0;
            rx_rd       <= '0;
            rx_level    <= '0;
            rx_overflow <= 1'b0;
        end else begin
            if (rx_drop) begin
                rx_cnt <= '0;
            end else if (rx_accept) begin
                rx_asm <= rx_word;
                rx_cnt <= rx_done ? '0 : rx_cnt + CW'(1);
            end
            rx_wr    <= rx_wr_n;
            rx_rd    <= rx_rd_n;
            rx_level <= rx_wr_n - rx_rd_n;
            if (ovf_set)      rx_overflow <= 1'b1;
            else if (ovf_clr) rx_overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_io_buffer.sv
// tb_uart_io_buffer: scoreboard bench for uart_io_buffer in three configurations
// (4-byte words, 1-byte words for overflow, 2-byte words for framing errors).
module tb_uart_io_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0]  tx_exp[$];
    logic [31:0] rx_exp[$];

    // uart_tx stand-in for DUT a: busy for busy_len cycles after each start, never reset
    int   busy_len  = 3;
    logic busy_hold = 1'b0;
    int   busy_cnt  = 0;

    uart_io_buffer_if #(.WORD_BYTES(4)) ia ();
    uart_io_buffer_if #(.WORD_BYTES(1)) ib ();
    uart_io_buffer_if #(.WORD_BYTES(2)) ic ();

    logic [7:0] a_tx_data, b_tx_data, c_tx_data;
    logic       a_tx_start, b_tx_start, c_tx_start, a_tx_busy;
    logic [7:0] a_rx_data, b_rx_data, c_rx_data;
    logic       a_rx_ready, b_rx_ready, c_rx_ready;
    logic       a_rx_ferr, b_rx_ferr, c_rx_ferr;
    logic [2:0] a_tx_level, a_rx_level, b_tx_level, b_rx_level, c_tx_level, c_rx_level;
    logic       a_ovf, b_ovf, c_ovf, a_ovf_clr, b_ovf_clr, c_ovf_clr;

    always @(posedge clk) begin
        if (a_tx_start)         busy_cnt <= busy_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign a_tx_busy = busy_hold | (busy_cnt != 0);

    uart_io_buffer #(.DEPTH_LOG2(2), .WORD_BYTES(4)) u_a (
        .clk(clk), .rst(rst), .core(ia), .tx_data(a_tx_data), .tx_start(a_tx_start),
        .tx_busy(a_tx_busy), .rx_data(a_rx_data), .rx_ready(a_rx_ready), .rx_ferr(a_rx_ferr),
        .tx_level(a_tx_level), .rx_level(a_rx_level), .rx_overflow(a_ovf), .ovf_clr(a_ovf_clr));

    uart_io_buffer #(.DEPTH_LOG2(2), .WORD_BYTES(1)) u_b (
        .clk(clk), .rst(rst), .core(ib), .tx_data(b_tx_data), .tx_start(b_tx_start),
        .tx_busy(1'b0), .rx_data(b_rx_data), .rx_ready(b_rx_ready), .rx_ferr(b_rx_ferr),
        .tx_level(b_tx_level), .rx_level(b_rx_level), .rx_overflow(b_ovf), .ovf_clr(b_ovf_clr));

    uart_io_buffer #(.DEPTH_LOG2(2), .WORD_BYTES(2)) u_c (
        .clk(clk), .rst(rst), .core(ic), .tx_data(c_tx_data), .tx_start(c_tx_start),
        .tx_busy(1'b0), .rx_data(c_rx_data), .rx_ready(c_rx_ready), .rx_ferr(c_rx_ferr),
        .tx_level(c_tx_level), .rx_level(c_rx_level), .rx_overflow(c_ovf), .ovf_clr(c_ovf_clr));

    // one received-byte strobe on the selected DUT, optionally with a pop and/or ovf_clr
    task automatic rx_byte(input int dut, input logic [7:0] b, input logic ferr,
                           input logic pop, input logic clr);
        @(posedge clk); #1;
        case (dut)
            1: begin b_rx_data = b; b_rx_ready = 1'b1; b_rx_ferr = ferr; ib.in_ready = pop; b_ovf_clr = clr; end
            2: begin c_rx_data = b; c_rx_ready = 1'b1; c_rx_ferr = ferr; ic.in_ready = pop; c_ovf_clr = clr; end
            default: begin a_rx_data = b; a_rx_ready = 1'b1; a_rx_ferr = ferr; ia.in_ready = pop; a_ovf_clr = clr; end
        endcase
        @(posedge clk); #1;
        a_rx_ready = 1'b0; b_rx_ready = 1'b0; c_rx_ready = 1'b0;
        a_rx_ferr  = 1'b0; b_rx_ferr  = 1'b0; c_rx_ferr  = 1'b0;
        ia.in_ready = 1'b0; ib.in_ready = 1'b0; ic.in_ready = 1'b0;
        a_ovf_clr  = 1'b0; b_ovf_clr  = 1'b0; c_ovf_clr  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({ia.out_ready, ia.in_valid, a_tx_start, a_ovf, a_tx_data, a_tx_level, a_rx_level, ia.in_data}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 32'h0}) begin
            fails++;
            $display("FAIL reset_a: got rdy=%b iv=%b st=%b ovf=%b txd=%h txl=%0d rxl=%0d ind=%h expected 1 0 0 0 00 0 0 00000000",
                     ia.out_ready, ia.in_valid, a_tx_start, a_ovf, a_tx_data, a_tx_level, a_rx_level, ia.in_data);
        end
        tests++;
        if ({ib.out_ready, ib.in_valid, b_rx_level, b_ovf} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset_b: got rdy=%b iv=%b rxl=%0d ovf=%b expected 1 0 0 0",
                     ib.out_ready, ib.in_valid, b_rx_level, b_ovf);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_tx_single();
        int last;
        int extra;
        logic [7:0] e;
        busy_len = 3;
        tx_exp = {8'h11, 8'h22, 8'h33, 8'h44};
        @(posedge clk); #1 ia.out_valid = 1'b1; ia.out_data = 32'h44332211;
        @(posedge clk); #1 ia.out_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (a_tx_level !== 3'd1 || a_tx_start !== 1'b0) begin
            fails++;
            $display("FAIL tx_level_after_push: got level=%0d start=%b expected 1 0", a_tx_level, a_tx_start);
        end
        last = -1;
        for (int n = 2; n < 80 && tx_exp.size() > 0; n++) begin
            @(negedge clk);
            if (n == 2) begin
                tests++;
                if (a_tx_start !== 1'b1 || a_tx_level !== 3'd0) begin
                    fails++;
                    $display("FAIL tx_latency: got start=%b level=%0d expected 1 0", a_tx_start, a_tx_level);
                end
            end
            if (a_tx_start === 1'b1) begin
                e = tx_exp.pop_front();
                tests++;
                if (a_tx_data !== e || a_tx_busy !== 1'b0) begin
                    fails++;
                    $display("FAIL tx_byte: got data=%h busy=%b expected %h 0", a_tx_data, a_tx_busy, e);
                end
                if (last >= 0) begin
                    tests++;
                    if (n - last != busy_len + 2) begin
                        fails++;
                        $display("FAIL tx_spacing: got %0d expected %0d", n - last, busy_len + 2);
                    end
                end
                last = n;
            end
        end
        tests++;
        if (tx_exp.size() != 0) begin
            fails++;
            $display("FAIL tx_single_timeout: got %0d bytes left expected 0", tx_exp.size());
            tx_exp.delete();
        end
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (a_tx_start === 1'b1) extra++;
        end
        tests++;
        if (extra != 0 || a_tx_level !== 3'd0) begin
            fails++;
            $display("FAIL tx_single_extra: got starts=%0d level=%0d expected 0 0", extra, a_tx_level);
        end
    endtask

    task automatic test_rx_assembly();
        logic [31:0] e;
        rx_exp.push_back(32'hDEADBEEF);
        rx_byte(4, 8'hEF, 1'b0, 1'b0, 1'b0);
        rx_byte(4, 8'hBE, 1'b0, 1'b0, 1'b0);
        rx_byte(4, 8'hAD, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        tests++;
        if (ia.in_valid !== 1'b0 || a_rx_level !== 3'd0) begin
            fails++;
            $display("FAIL rx_partial: got valid=%b level=%0d expected 0 0", ia.in_valid, a_rx_level);
        end
        rx_byte(4, 8'hDE, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        e = rx_exp.pop_front();
        tests++;
        if (ia.in_valid !== 1'b1 || ia.in_data !== e || a_rx_level !== 3'd1) begin
            fails++;
            $display("FAIL rx_word: got valid=%b data=%h level=%0d expected 1 %h 1",
                     ia.in_valid, ia.in_data, a_rx_level, e);
        end
        @(posedge clk); #1 ia.in_ready = 1'b1;
        @(posedge clk); #1 ia.in_ready = 1'b0;
        @(negedge clk);
        tests++;
        if (ia.in_valid !== 1'b0 || a_rx_level !== 3'd0) begin
            fails++;
            $display("FAIL rx_pop: got valid=%b level=%0d expected 0 0", ia.in_valid, a_rx_level);
        end
    endtask

    task automatic test_rx_overflow();
        logic [31:0] e;
        for (int i = 1; i <= 5; i++) begin
            rx_byte(1, 8'(i), 1'b0, 1'b0, 1'b0);
            if (i <= 4) rx_exp.push_back(32'(i));
            if (i == 4) begin
                @(negedge clk);
                tests++;
                if (b_rx_level !== 3'd4 || b_ovf !== 1'b0 || ib.out_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL ovf_full_no_ovf: got level=%0d ovf=%b expected 4 0", b_rx_level, b_ovf);
                end
            end
        end
        @(negedge clk);
        e = rx_exp[0];
        tests++;
        if (b_rx_level !== 3'd4 || b_ovf !== 1'b1 || ib.in_data !== e[7:0]) begin
            fails++;
            $display("FAIL ovf_set: got level=%0d ovf=%b head=%h expected 4 1 %h", b_rx_level, b_ovf, ib.in_data, e[7:0]);
        end
        @(posedge clk); #1 b_ovf_clr = 1'b1;
        @(posedge clk); #1 b_ovf_clr = 1'b0;
        @(negedge clk);
        tests++;
        if (b_ovf !== 1'b0) begin
            fails++;
            $display("FAIL ovf_clr: got %b expected 0", b_ovf);
        end
        e = rx_exp.pop_front();
        rx_byte(1, 8'h06, 1'b0, 1'b1, 1'b0);
        rx_exp.push_back(32'h06);
        @(negedge clk);
        tests++;
        if (b_rx_level !== 3'd4 || b_ovf !== 1'b0) begin
            fails++;
            $display("FAIL ovf_push_pop: got level=%0d ovf=%b expected 4 0", b_rx_level, b_ovf);
        end
        rx_byte(1, 8'h07, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        tests++;
        if (b_ovf !== 1'b1 || b_rx_level !== 3'd4) begin
            fails++;
            $display("FAIL ovf_set_wins: got ovf=%b level=%0d expected 1 4", b_ovf, b_rx_level);
        end
        while (rx_exp.size() > 0) begin
            e = rx_exp.pop_front();
            @(negedge clk);
            tests++;
            if (ib.in_valid !== 1'b1 || ib.in_data !== e[7:0]) begin
                fails++;
                $display("FAIL ovf_drain: got valid=%b data=%h expected 1 %h", ib.in_valid, ib.in_data, e[7:0]);
            end
            @(posedge clk); #1 ib.in_ready = 1'b1;
            @(posedge clk); #1 ib.in_ready = 1'b0;
        end
        @(negedge clk);
        tests++;
        if (ib.in_valid !== 1'b0 || b_rx_level !== 3'd0) begin
            fails++;
            $display("FAIL ovf_empty: got valid=%b level=%0d expected 0 0", ib.in_valid, b_rx_level);
        end
    endtask

    task automatic test_tx_full();
        int k;
        int extra;
        logic [7:0] e;
        busy_len  = 3;
        busy_hold = 1'b1;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            ia.out_valid = 1'b1;
            ia.out_data  = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            @(negedge clk);
            if (ia.out_ready === 1'b1) begin
                tx_exp.push_back(8'(4*k)); tx_exp.push_back(8'(4*k+1));
                tx_exp.push_back(8'(4*k+2)); tx_exp.push_back(8'(4*k+3));
                k++;
            end
            if (a_tx_start === 1'b1) begin
                e = (tx_exp.size() > 0) ? tx_exp.pop_front() : 8'hxx;
                tests++;
                if (a_tx_data !== e) begin
                    fails++;
                    $display("FAIL txfull_byte_hold: got %h expected %h", a_tx_data, e);
                end
            end
        end
        @(posedge clk); #1 ia.out_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (k != 5 || ia.out_ready !== 1'b0 || a_tx_level !== 3'd4) begin
            fails++;
            $display("FAIL tx_full: got accepted=%0d ready=%b level=%0d expected 5 0 4", k, ia.out_ready, a_tx_level);
        end
        busy_hold = 1'b0;
        for (int n = 0; n < 400 && tx_exp.size() > 0; n++) begin
            @(negedge clk);
            if (a_tx_start === 1'b1) begin
                e = tx_exp.pop_front();
                tests++;
                if (a_tx_data !== e) begin
                    fails++;
                    $display("FAIL txfull_byte: got %h expected %h", a_tx_data, e);
                end
            end
        end
        tests++;
        if (tx_exp.size() != 0) begin
            fails++;
            $display("FAIL txfull_timeout: got %0d bytes left expected 0", tx_exp.size());
            tx_exp.delete();
        end
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (a_tx_start === 1'b1) extra++;
        end
        tests++;
        if (extra != 0 || a_tx_level !== 3'd0 || ia.out_ready !== 1'b1) begin
            fails++;
            $display("FAIL txfull_drained: got starts=%0d level=%0d ready=%b expected 0 0 1", extra, a_tx_level, ia.out_ready);
        end
    endtask

    task automatic test_ferr();
        logic [31:0] e;
        int n;
`ifdef UART_IO_FERR_DROP_EN
        rx_exp.push_back(32'h0403);
`else
        rx_exp.push_back(32'h0201);
        rx_exp.push_back(32'h0403);
`endif
        n = rx_exp.size();
        rx_byte(2, 8'h01, 1'b0, 1'b0, 1'b0);
        rx_byte(2, 8'h02, 1'b1, 1'b0, 1'b0);
        rx_byte(2, 8'h03, 1'b0, 1'b0, 1'b0);
        rx_byte(2, 8'h04, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        tests++;
        if (c_rx_level !== 3'(n)) begin
            fails++;
            $display("FAIL ferr_level: got %0d expected %0d", c_rx_level, n);
        end
        while (rx_exp.size() > 0) begin
            e = rx_exp.pop_front();
            @(negedge clk);
            tests++;
            if (ic.in_valid !== 1'b1 || ic.in_data !== e[15:0]) begin
                fails++;
                $display("FAIL ferr_word: got valid=%b data=%h expected 1 %h", ic.in_valid, ic.in_data, e[15:0]);
            end
            @(posedge clk); #1 ic.in_ready = 1'b1;
            @(posedge clk); #1 ic.in_ready = 1'b0;
        end
        @(negedge clk);
        tests++;
        if (ic.in_valid !== 1'b0) begin
            fails++;
            $display("FAIL ferr_extra_word: got valid=%b data=%h expected 0", ic.in_valid, ic.in_data);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        logic [31:0] e;
        busy_len = 8;
        @(posedge clk); #1 ia.out_valid = 1'b1; ia.out_data = 32'hCAFEF00D;
        @(posedge clk); #1 ia.out_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (a_tx_start === 1'b1) seen = 1'b1;
        end
        tests++;
        if (!seen || a_tx_data !== 8'h0D) begin
            fails++;
            $display("FAIL rstmid_txstart: got seen=%b data=%h expected 1 0d", seen, a_tx_data);
        end
        rx_byte(4, 8'h55, 1'b0, 1'b0, 1'b0);
        rx_byte(4, 8'h66, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({ia.out_ready, ia.in_valid, a_tx_start, a_ovf, a_tx_data, a_tx_level, a_rx_level, ia.in_data}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 32'h0}) begin
            fails++;
            $display("FAIL rstmid_values: got rdy=%b iv=%b st=%b ovf=%b txd=%h txl=%0d rxl=%0d ind=%h expected 1 0 0 0 00 0 0 00000000",
                     ia.out_ready, ia.in_valid, a_tx_start, a_ovf, a_tx_data, a_tx_level, a_rx_level, ia.in_data);
        end
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 20 && busy_cnt != 0; i++) @(negedge clk);
        rx_exp.push_back(32'h44332211);
        rx_byte(4, 8'h11, 1'b0, 1'b0, 1'b0);
        rx_byte(4, 8'h22, 1'b0, 1'b0, 1'b0);
        rx_byte(4, 8'h33, 1'b0, 1'b0, 1'b0);
        rx_byte(4, 8'h44, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        e = rx_exp.pop_front();
        tests++;
        if (ia.in_valid !== 1'b1 || ia.in_data !== e || a_rx_level !== 3'd1 || a_tx_start !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_rx_word: got valid=%b data=%h level=%0d start=%b expected 1 %h 1 0",
                     ia.in_valid, ia.in_data, a_rx_level, a_tx_start, e);
        end
        @(posedge clk); #1 ia.in_ready = 1'b1;
        @(posedge clk); #1 ia.in_ready = 1'b0;
    endtask

    initial begin
        ia.out_valid = 1'b0; ia.out_data = '0; ia.in_ready = 1'b0;
        ib.out_valid = 1'b0; ib.out_data = '0; ib.in_ready = 1'b0;
        ic.out_valid = 1'b0; ic.out_data = '0; ic.in_ready = 1'b0;
        a_rx_data = '0; b_rx_data = '0; c_rx_data = '0;
        a_rx_ready = 1'b0; b_rx_ready = 1'b0; c_rx_ready = 1'b0;
        a_rx_ferr = 1'b0; b_rx_ferr = 1'b0; c_rx_ferr = 1'b0;
        a_ovf_clr = 1'b0; b_ovf_clr = 1'b0; c_ovf_clr = 1'b0;

        test_reset();
        test_tx_single();
        test_rx_assembly();
        test_rx_overflow();
        test_tx_full();
        test_ferr();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
